// File: rtl/mips_pkg.sv
// Shared register-file types and constants for the writeback path.
package mips_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_FIFO,
    WB_BYPASS
  } wb_src_e;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wbEntry_t;

  localparam int unsigned ENTRY_W = $bits(wbEntry_t);

endpackage

// File: rtl/reg_writeback_arbiter_if.sv
// Pipeline-facing bundle of the writeback arbiter: ALU/mem results, issue, hazard query, RF write port.
interface reg_writeback_arbiter_if;
  import mips_pkg::*;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_data;
  logic              alu_stall;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0] mem_data;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_dest;
  logic [ADDR_W-1:0] chk_rs;
  logic [ADDR_W-1:0] chk_rt;
  logic              busy_rs;
  logic              busy_rt;
  logic              regWrite;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic              err_waw;

  modport master (
    output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
           issue_valid, issue_dest, chk_rs, chk_rt,
    input  alu_stall, mem_ready, busy_rs, busy_rt, regWrite, writeReg, writeData, err_waw
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
           issue_valid, issue_dest, chk_rs, chk_rt,
    output alu_stall, mem_ready, busy_rs, busy_rt, regWrite, writeReg, writeData, err_waw
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering long-latency results; push while full is honoured only with a pop.
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic             doPush;
  logic             doPop;

  assign doPop  = pop & (count != '0);
  assign doPush = push & ((count != CNT_W'(DEPTH)) | doPop);

  // Power-of-two depth lets the pointers wrap by overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

  assign dout = mem[rdPtr];

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Merges ALU and long-latency results onto the single register-file write port,
// with a starvation guard for buffered results and a pending-destination scoreboard.
module reg_writeback_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  reg_writeback_arbiter_if.slave wb
);

  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  wbEntry_t             fifoIn;
  wbEntry_t             fifoHead;
  logic [CNT_W-1:0]     fifoCount;
  logic                 fifoEmpty;
  logic                 fifoPush;
  logic                 fifoPop;
  logic                 memReady;
  logic                 memXfer;
  logic                 aluStall;
  logic                 starved;
  logic [STARVE_W-1:0]  starveCnt;
  logic [STARVE_W-1:0]  starveNext;
  logic [NUM_REGS-1:0]  pend;
  logic [NUM_REGS-1:0]  pendNext;
  logic                 errNext;
  wb_src_e              wbSrc;
  logic [ADDR_W-1:0]    selDest;
  logic [DATA_W-1:0]    selData;

  assign fifoIn = '{dest: wb.mem_dest, data: wb.mem_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifoPush),
    .pop   (fifoPop),
    .din   (fifoIn),
    .dout  (fifoHead),
    .count (fifoCount)
  );

  // Write-port selection: a starved head beats the ALU, otherwise ALU > FIFO > bypass.
  always_comb begin
    wbSrc     = WB_NONE;
    selDest   = REG_ZERO;
    selData   = '0;
    memReady  = 1'b0;
    memXfer   = 1'b0;
    aluStall  = 1'b0;
    fifoPush  = 1'b0;
    fifoPop   = 1'b0;
    fifoEmpty = (fifoCount == '0);
    starved   = !fifoEmpty && (starveCnt == STARVE_W'(STARVE_MAX));
    if (rst_n) begin
      memReady = (fifoCount < CNT_W'(FIFO_DEPTH)) | (fifoEmpty & ~wb.alu_valid);
      memXfer  = wb.mem_valid & memReady;
      if (starved)             wbSrc = WB_FIFO;
      else if (wb.alu_valid)   wbSrc = WB_ALU;
      else if (!fifoEmpty)     wbSrc = WB_FIFO;
      else if (memXfer)        wbSrc = WB_BYPASS;
      aluStall = wb.alu_valid & (wbSrc != WB_ALU);
      fifoPop  = (wbSrc == WB_FIFO);
      fifoPush = memXfer & (wbSrc != WB_BYPASS);
    end
    case (wbSrc)
      WB_ALU:    begin selDest = wb.alu_dest;   selData = wb.alu_data;   end
      WB_FIFO:   begin selDest = fifoHead.dest; selData = fifoHead.data; end
      WB_BYPASS: begin selDest = wb.mem_dest;   selData = wb.mem_data;   end
      default:   ;
    endcase
  end

  // Starvation counter, scoreboard and WAW flag next-state.
  always_comb begin
    starveNext = starveCnt;
    if (fifoEmpty || fifoPop)
      starveNext = '0;
    else if (starveCnt != STARVE_W'(STARVE_MAX))
      starveNext = starveCnt + STARVE_W'(1);

    pendNext = pend;
    if (wbSrc == WB_FIFO || wbSrc == WB_BYPASS) pendNext[selDest] = 1'b0;
    if (wb.issue_valid) pendNext[wb.issue_dest] = 1'b1;
    pendNext[REG_ZERO] = 1'b0;

    errNext = wb.err_waw | ((wbSrc == WB_ALU) && (selDest != REG_ZERO) && pend[selDest]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starveCnt    <= '0;
      pend         <= '0;
      wb.regWrite  <= 1'b0;
      wb.writeReg  <= REG_ZERO;
      wb.writeData <= '0;
      wb.err_waw   <= 1'b0;
    end else begin
      starveCnt    <= starveNext;
      pend         <= pendNext;
      wb.regWrite  <= (wbSrc != WB_NONE) && (selDest != REG_ZERO);
      wb.writeReg  <= selDest;
      wb.writeData <= selData;
      wb.err_waw   <= errNext;
    end
  end

  assign wb.mem_ready = memReady;
  assign wb.alu_stall = aluStall;
  assign wb.busy_rs   = pend[wb.chk_rs];
  assign wb.busy_rt   = pend[wb.chk_rt];

endmodule
